threewire_slave_ctrl: RTL and testbench
=======================================

// Module: threewire_slave_ctrl
// PURPOSE
//  Responder end of the 3-wire bus driven by threewire_master_ctrl.
//  Oversamples SCLK/CS/SDIO in the in_clk domain and decodes each frame: 1 R/W bit, address, data.
//  Turns frames into single-cycle register-file accesses.
//  On reads it drives SDIO back to the master.
//  Used in test fixtures and loopback boards as the far-side peripheral.
// PARAMETERS
//  TWS_ADDRESS_BITS  10  address field width, MSB first
//  TWS_DATA_BITS     32  data field width, MSB first
// PORTS
//  in_clk           in     1     system clock, sole clock
//  in_rst           in     1     synchronous reset, active-high
//  in_tw_clock      in     1     bus SCLK (async to in_clk)
//  in_tw_cs         in     1     bus chip select, active-low (async)
//  io_tw_data       inout  1     bus SDIO; driven only while out_tw_dir=1, else 'z'
//  out_tw_dir       out    1     1 = slave driving SDIO (read data phase)
//  out_reg_addr     out    AB    captured address, held until next frame's address completes
//  out_reg_wr_en    out    1     1-cycle write strobe
//  out_reg_wr_data  out    DB    write data, valid with out_reg_wr_en
//  out_reg_rd_en    out    1     1-cycle read request
//  in_reg_rd_data   in     DB    read data, sampled exactly 1 in_clk after out_reg_rd_en
//  out_busy         out    1     1 from CS fall (sync'd) until frame end/abort
//  out_frame_err    out    1     1-cycle pulse on CS rise before frame complete
// BEHAVIOUR
//  Sync: SCLK, CS and SDIO each pass a 2-FF synchroniser plus an edge-detect FF.
//   Rise/fall events reach the FSM 3 in_clk after the pin edge.
//   Requires SCLK half-period >= 6 in_clk.
//  Bus rules: master changes SDIO on SCLK fall; both sides sample on SCLK rise.
//   Slave launches read bits on SCLK fall.
//   R/W bit: 1 = write, 0 = read.
//  Reset values: out_tw_dir=0, out_reg_wr_en=0, out_reg_rd_en=0, out_busy=0, out_frame_err=0, addr/data regs=0.
//   State=IDLE, io_tw_data='z'.
//  FSM (bit_cnt width = _clog2(max(AB,DB))):
//   IDLE: CS fall event -> CMD, out_busy=1, bit_cnt cleared.
//   CMD: SCLK rise -> latch R/W -> ADDR, bit_cnt=AB-1.
//   ADDR: each SCLK rise shifts SDIO into addr; at bit_cnt==0 branch on R/W:
//    write -> WR_DATA, bit_cnt=DB-1.
//    read -> pulse out_reg_rd_en (next cycle), latch in_reg_rd_data 1 cycle later into shift reg -> RD_DATA.
//   WR_DATA: shift on SCLK rise; last bit -> out_reg_wr_en pulse next in_clk with full word -> DONE.
//   RD_DATA: out_tw_dir=1 from entry.
//    Each SCLK fall presents the next bit, MSB first, first bit on the first fall after the last address rise.
//    After bit 0 is held through its rise, the next fall drops out_tw_dir -> DONE.
//   DONE: ignore SCLK; CS rise -> IDLE, out_busy=0.
//  Boundaries:
//   CS rise in CMD/ADDR/WR_DATA/RD_DATA -> IDLE; out_frame_err 1-cycle pulse; out_tw_dir=0 same cycle; no wr_en.
//   CS rise and SCLK edge in same sync cycle: CS wins, the edge is discarded.
//   Extra SCLK cycles in DONE: ignored, no second strobe.
//   Reset mid-frame: all outputs to reset values, SDIO released.
//    FSM waits for a CS rise before accepting a new CS fall, so a partial frame is never decoded.
//   CS low at reset release: treated as the partial-frame case above.
//   out_reg_wr_en and out_reg_rd_en are never high together; each is at most once per frame.
// STRUCTURE
//  `include "builtins_redefined.v" for _clog2/_cdiv.
//  Shared include threewire_defs.v holds the constants used by master and slave:
//   TW_RW_READ=0, TW_RW_WRITE=1, TW_CS_ACTIVE=0.
//  One sub-module: tw_sync_edge (2-FF sync + rise/fall pulses), instantiated for SCLK, CS and SDIO.
//  Slave FSM, counters and shift registers stay in this module.
// TESTING
//  Directed scenarios, with threewire_master_ctrl (CLK_DIV_2N=4) as the bus driver:
//  1. Write addr 0x155, data 0xDEADBEEF.
//     -> one wr_en pulse, addr=0x155, wr_data=0xDEADBEEF, no rd_en, err=0.
//  2. Read addr 0x3FF with in_reg_rd_data=0xA5A55A5A.
//     -> one rd_en, master out_rd_data=0xA5A55A5A, out_tw_dir low after frame.
//  3. CS rises after 5 address bits of a write.
//     -> frame_err pulse, no wr_en, busy=0, next full write to 0x001 decodes correctly.
//  4. in_rst asserted mid-read for 1 cycle with CS still low.
//     -> out_tw_dir=0 next cycle, no strobes until CS high.
//     -> subsequent read of 0x010 returns correct data.
//  5. Back-to-back write then read of addr 0x2AA with minimum CS-high gap (2 SCLK periods).
//     -> read returns written value via loopback register model.
//  6. 4 extra SCLK cycles after a write before CS rises.
//     -> exactly one wr_en, no frame_err.

Source files
------------

// File: rtl/threewire_slave_ctrl_pkg.sv
// Shared constants, state encoding and elaboration helpers for the 3-wire slave.
package threewire_slave_ctrl_pkg;

    localparam int TWS_ADDRESS_BITS_DEF = 10;
    localparam int TWS_DATA_BITS_DEF    = 32;

    // Bus-level constants shared with the master side.
    localparam logic TW_RW_READ   = 1'b0;
    localparam logic TW_RW_WRITE  = 1'b1;
    localparam logic TW_CS_ACTIVE = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CMD      = 4'd1,
        ST_ADDR     = 4'd2,
        ST_RD_WAIT  = 4'd3,
        ST_RD_LATCH = 4'd4,
        ST_RD_DATA  = 4'd5,
        ST_WR_DATA  = 4'd6,
        ST_DONE     = 4'd7
    } tws_state_t;

    // Ceiling log2, used to size the bit counter.
    function automatic int tw_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int tw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/threewire_slave_ctrl_sync_edge.sv
// Two-flop synchroniser plus edge-detect flop for one asynchronous bus pin.
// Edge pulses are combinational from flops and are consumed by the FSM on the
// third in_clk edge after the pin transition.
module tw_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_async,
    output logic out_level,
    output logic out_rise,
    output logic out_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain and delayed copy for edge detection.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= in_async;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign out_level = sync_r;
    assign out_rise  = sync_r & ~prev_r;
    assign out_fall  = ~sync_r & prev_r;

endmodule

// File: rtl/threewire_slave_ctrl.sv
// 3-wire bus responder: oversamples SCLK/CS/SDIO, decodes R/W + address + data
// frames and turns them into single-cycle register-file strobes; drives SDIO
// back to the master during the read data phase.
module threewire_slave_ctrl
    import threewire_slave_ctrl_pkg::*;
#(
    parameter int TWS_ADDRESS_BITS = TWS_ADDRESS_BITS_DEF,
    parameter int TWS_DATA_BITS    = TWS_DATA_BITS_DEF
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_tw_clock,
    input  logic                        in_tw_cs,
    inout  wire                         io_tw_data,
    output logic                        out_tw_dir,
    output logic [TWS_ADDRESS_BITS-1:0] out_reg_addr,
    output logic                        out_reg_wr_en,
    output logic [TWS_DATA_BITS-1:0]    out_reg_wr_data,
    output logic                        out_reg_rd_en,
    input  logic [TWS_DATA_BITS-1:0]    in_reg_rd_data,
    output logic                        out_busy,
    output logic                        out_frame_err
);

    localparam int CNT_W = tw_clog2(tw_max(TWS_ADDRESS_BITS, TWS_DATA_BITS));

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sdio_level_s, sdio_rise_s, sdio_fall_s;
    logic unused_sync_s;
    logic mid_frame_s;

    tws_state_t                  state_r;
    logic [CNT_W-1:0]            bit_cnt_r;
    logic                        rw_r;
    logic                        rd_last_r;
    logic                        sdo_r;
    logic [TWS_ADDRESS_BITS-1:0] addr_shift_r;
    logic [TWS_DATA_BITS-1:0]    data_shift_r;

    tw_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .in_clk(in_clk), .in_rst(in_rst), .in_async(in_tw_clock),
        .out_level(sclk_level_s), .out_rise(sclk_rise_s), .out_fall(sclk_fall_s)
    );

    // CS resets to the active level so a CS held low through reset never
    // produces a fall event; a full CS rise is needed before the next frame.
    tw_sync_edge #(.RST_VAL(TW_CS_ACTIVE)) u_sync_cs (
        .in_clk(in_clk), .in_rst(in_rst), .in_async(in_tw_cs),
        .out_level(cs_level_s), .out_rise(cs_rise_s), .out_fall(cs_fall_s)
    );

    tw_sync_edge #(.RST_VAL(1'b0)) u_sync_sdio (
        .in_clk(in_clk), .in_rst(in_rst), .in_async(io_tw_data),
        .out_level(sdio_level_s), .out_rise(sdio_rise_s), .out_fall(sdio_fall_s)
    );

    assign unused_sync_s = ^{sclk_level_s, cs_level_s, sdio_rise_s, sdio_fall_s};

    assign io_tw_data = out_tw_dir ? sdo_r : 1'bz;

    // Flags states in which a CS rise means the frame was cut short.
    always_comb begin
        mid_frame_s = 1'b0;
        case (state_r)
            ST_CMD, ST_ADDR, ST_RD_WAIT, ST_RD_LATCH,
            ST_RD_DATA, ST_WR_DATA: mid_frame_s = 1'b1;
            default:                mid_frame_s = 1'b0;
        endcase
    end

    // Frame decoder FSM with registered strobes and bus direction.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_r         <= ST_IDLE;
            bit_cnt_r       <= '0;
            rw_r            <= TW_RW_READ;
            rd_last_r       <= 1'b0;
            sdo_r           <= 1'b0;
            addr_shift_r    <= '0;
            data_shift_r    <= '0;
            out_tw_dir      <= 1'b0;
            out_reg_addr    <= '0;
            out_reg_wr_en   <= 1'b0;
            out_reg_wr_data <= '0;
            out_reg_rd_en   <= 1'b0;
            out_busy        <= 1'b0;
            out_frame_err   <= 1'b0;
        end else begin
            out_reg_wr_en <= 1'b0;
            out_reg_rd_en <= 1'b0;
            out_frame_err <= 1'b0;
            if (cs_rise_s && mid_frame_s) begin
                // CS wins over any SCLK edge in the same cycle.
                state_r       <= ST_IDLE;
                out_busy      <= 1'b0;
                out_tw_dir    <= 1'b0;
                out_frame_err <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_fall_s) begin
                            state_r   <= ST_CMD;
                            out_busy  <= 1'b1;
                            bit_cnt_r <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise_s) begin
                            rw_r      <= sdio_level_s;
                            bit_cnt_r <= CNT_W'(TWS_ADDRESS_BITS - 1);
                            state_r   <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise_s) begin
                            addr_shift_r <= {addr_shift_r[TWS_ADDRESS_BITS-2:0], sdio_level_s};
                            if (bit_cnt_r == '0) begin
                                out_reg_addr <= {addr_shift_r[TWS_ADDRESS_BITS-2:0], sdio_level_s};
                                if (rw_r == TW_RW_WRITE) begin
                                    bit_cnt_r <= CNT_W'(TWS_DATA_BITS - 1);
                                    state_r   <= ST_WR_DATA;
                                end else begin
                                    out_reg_rd_en <= 1'b1;
                                    state_r       <= ST_RD_WAIT;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        // Register file answers in the cycle after the request.
                        state_r <= ST_RD_LATCH;
                    end
                    ST_RD_LATCH: begin
                        data_shift_r <= in_reg_rd_data;
                        bit_cnt_r    <= CNT_W'(TWS_DATA_BITS - 1);
                        rd_last_r    <= 1'b0;
                        sdo_r        <= 1'b0;
                        out_tw_dir   <= 1'b1;
                        state_r      <= ST_RD_DATA;
                    end
                    ST_RD_DATA: begin
                        if (sclk_fall_s) begin
                            if (rd_last_r) begin
                                out_tw_dir <= 1'b0;
                                state_r    <= ST_DONE;
                            end else begin
                                sdo_r        <= data_shift_r[TWS_DATA_BITS-1];
                                data_shift_r <= {data_shift_r[TWS_DATA_BITS-2:0], 1'b0};
                                if (bit_cnt_r == '0) begin
                                    rd_last_r <= 1'b1;
                                end else begin
                                    bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (sclk_rise_s) begin
                            data_shift_r <= {data_shift_r[TWS_DATA_BITS-2:0], sdio_level_s};
                            if (bit_cnt_r == '0) begin
                                out_reg_wr_en   <= 1'b1;
                                out_reg_wr_data <= {data_shift_r[TWS_DATA_BITS-2:0], sdio_level_s};
                                state_r         <= ST_DONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (cs_rise_s) begin
                            state_r  <= ST_IDLE;
                            out_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        out_busy   <= 1'b0;
                        out_tw_dir <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// Directed bench: emulates the bus master with SCLK half-period of 8 in_clk and
// a loopback register-file model behind the slave.
module tb_threewire_slave_ctrl;

    localparam int HALF = 8;
    localparam int GAP  = 4 * HALF;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_tw_clock;
    logic        in_tw_cs;
    logic        m_en;
    logic        m_sdo;
    wire         io_tw_data;
    logic        out_tw_dir;
    logic [9:0]  out_reg_addr;
    logic        out_reg_wr_en;
    logic [31:0] out_reg_wr_data;
    logic        out_reg_rd_en;
    logic [31:0] in_reg_rd_data = 32'h0;
    logic        out_busy;
    logic        out_frame_err;

    logic [31:0] mem [0:1023];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    logic [9:0]  wr_addr_seen = 10'h0;
    logic [31:0] wr_data_seen = 32'h0;
    logic [31:0] rdata;
    logic        bit_s;

    always #5 in_clk = ~in_clk;

    assign io_tw_data = m_en ? m_sdo : 1'bz;

    threewire_slave_ctrl dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_tw_clock     (in_tw_clock),
        .in_tw_cs        (in_tw_cs),
        .io_tw_data      (io_tw_data),
        .out_tw_dir      (out_tw_dir),
        .out_reg_addr    (out_reg_addr),
        .out_reg_wr_en   (out_reg_wr_en),
        .out_reg_wr_data (out_reg_wr_data),
        .out_reg_rd_en   (out_reg_rd_en),
        .in_reg_rd_data  (in_reg_rd_data),
        .out_busy        (out_busy),
        .out_frame_err   (out_frame_err)
    );

    // Register file model and strobe monitors.
    always @(posedge in_clk) begin
        if (out_reg_wr_en) mem[out_reg_addr] <= out_reg_wr_data;
        if (out_reg_rd_en) in_reg_rd_data <= mem[out_reg_addr];
        if (!in_rst) begin
            if (out_reg_wr_en) begin
                wr_cnt       <= wr_cnt + 1;
                wr_addr_seen <= out_reg_addr;
                wr_data_seen <= out_reg_wr_data;
            end
            if (out_reg_rd_en) rd_cnt <= rd_cnt + 1;
            if (out_frame_err) err_cnt <= err_cnt + 1;
            if (out_reg_wr_en && out_reg_rd_en) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic start_frame();
        in_tw_clock = 1'b0;
        in_tw_cs    = 1'b0;
    endtask

    // Master drives one bit: data changes with SCLK low, slave samples on rise.
    task automatic drive_bit(input logic b, input logic release_after);
        m_en  = 1'b1;
        m_sdo = b;
        wait_clks(HALF);
        in_tw_clock = 1'b1;
        if (release_after) begin
            wait_clks(3);
            m_en = 1'b0;
            wait_clks(HALF - 3);
        end else begin
            wait_clks(HALF);
        end
        in_tw_clock = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clks(HALF);
        b = io_tw_data;
        in_tw_clock = 1'b1;
        wait_clks(HALF);
        in_tw_clock = 1'b0;
    endtask

    task automatic idle_sclk();
        wait_clks(HALF);
        in_tw_clock = 1'b1;
        wait_clks(HALF);
        in_tw_clock = 1'b0;
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        m_en     = 1'b0;
        in_tw_cs = 1'b1;
        wait_clks(GAP);
    endtask

    task automatic send_header(input logic rw, input logic [9:0] addr);
        drive_bit(rw, 1'b0);
        for (int i = 9; i >= 0; i--) drive_bit(addr[i], (rw == 1'b0) && (i == 0));
    endtask

    task automatic write_frame(input logic [9:0] addr, input logic [31:0] data, input int extra);
        start_frame();
        send_header(1'b1, addr);
        check("busy_in_frame", 32'(out_busy), 32'd1);
        for (int i = 31; i >= 0; i--) drive_bit(data[i], 1'b0);
        for (int i = 0; i < extra; i++) idle_sclk();
        end_frame();
    endtask

    task automatic read_frame(input logic [9:0] addr, output logic [31:0] data);
        logic b;
        data = 32'h0;
        start_frame();
        send_header(1'b0, addr);
        for (int i = 0; i < 32; i++) begin
            recv_bit(b);
            data = {data[30:0], b};
            if (i == 0) check("rd_dir_active", 32'(out_tw_dir), 32'd1);
        end
        end_frame();
    endtask

    initial begin
        in_rst      = 1'b1;
        in_tw_clock = 1'b0;
        in_tw_cs    = 1'b1;
        m_en        = 1'b0;
        m_sdo       = 1'b0;
        wait_clks(5);
        // Reset state
        check("rst_dir",     32'(out_tw_dir),      32'd0);
        check("rst_wr_en",   32'(out_reg_wr_en),   32'd0);
        check("rst_rd_en",   32'(out_reg_rd_en),   32'd0);
        check("rst_busy",    32'(out_busy),        32'd0);
        check("rst_err",     32'(out_frame_err),   32'd0);
        check("rst_addr",    32'(out_reg_addr),    32'd0);
        check("rst_wr_data", out_reg_wr_data,      32'd0);
        in_rst = 1'b0;
        wait_clks(GAP);

        // 1: plain write
        write_frame(10'h155, 32'hDEADBEEF, 0);
        check("s1_wr_cnt",  32'(wr_cnt),       32'd1);
        check("s1_wr_addr", 32'(wr_addr_seen), 32'h155);
        check("s1_wr_data", wr_data_seen,      32'hDEADBEEF);
        check("s1_rd_cnt",  32'(rd_cnt),       32'd0);
        check("s1_err_cnt", 32'(err_cnt),      32'd0);
        check("s1_busy",    32'(out_busy),     32'd0);
        check("s1_addr_out", 32'(out_reg_addr), 32'h155);

        // 2: read of 0x3FF, preloaded through the bus
        write_frame(10'h3FF, 32'hA5A55A5A, 0);
        read_frame(10'h3FF, rdata);
        check("s2_rdata",   rdata,            32'hA5A55A5A);
        check("s2_rd_cnt",  32'(rd_cnt),      32'd1);
        check("s2_wr_cnt",  32'(wr_cnt),      32'd2);
        check("s2_dir",     32'(out_tw_dir),  32'd0);
        check("s2_addr_out", 32'(out_reg_addr), 32'h3FF);

        // 3: CS rises after 5 address bits of a write
        start_frame();
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        end_frame();
        check("s3_err_cnt", 32'(err_cnt),  32'd1);
        check("s3_wr_cnt",  32'(wr_cnt),   32'd2);
        check("s3_busy",    32'(out_busy), 32'd0);
        write_frame(10'h001, 32'h12345678, 0);
        check("s3_wr_cnt2",  32'(wr_cnt),       32'd3);
        check("s3_wr_addr",  32'(wr_addr_seen), 32'h001);
        check("s3_wr_data",  wr_data_seen,      32'h12345678);

        // 4: reset pulse mid-read with CS held low
        write_frame(10'h010, 32'h0BADF00D, 0);
        start_frame();
        send_header(1'b0, 10'h010);
        for (int i = 0; i < 8; i++) recv_bit(bit_s);
        check("s4_dir_pre", 32'(out_tw_dir), 32'd1);
        in_rst = 1'b1;
        wait_clks(1);
        in_rst = 1'b0;
        check("s4_dir_post",  32'(out_tw_dir), 32'd0);
        check("s4_busy_post", 32'(out_busy),   32'd0);
        for (int i = 0; i < 24; i++) recv_bit(bit_s);
        check("s4_busy_tail", 32'(out_busy), 32'd0);
        end_frame();
        check("s4_rd_cnt",  32'(rd_cnt),  32'd2);
        check("s4_wr_cnt",  32'(wr_cnt),  32'd4);
        check("s4_err_cnt", 32'(err_cnt), 32'd1);
        read_frame(10'h010, rdata);
        check("s4_rdata",   rdata,        32'h0BADF00D);
        check("s4_rd_cnt2", 32'(rd_cnt),  32'd3);

        // 5: back-to-back write then read with minimum CS-high gap
        write_frame(10'h2AA, 32'h5A5AC3C3, 0);
        read_frame(10'h2AA, rdata);
        check("s5_rdata",  rdata,       32'h5A5AC3C3);
        check("s5_wr_cnt", 32'(wr_cnt), 32'd5);
        check("s5_rd_cnt", 32'(rd_cnt), 32'd4);

        // 6: extra SCLK cycles after a write
        write_frame(10'h0F0, 32'hCAFEF00D, 4);
        check("s6_wr_cnt",  32'(wr_cnt),       32'd6);
        check("s6_wr_data", wr_data_seen,      32'hCAFEF00D);
        check("s6_wr_addr", 32'(wr_addr_seen), 32'h0F0);
        check("s6_err_cnt", 32'(err_cnt),      32'd1);
        check("both_strobes", 32'(both_cnt),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
